pixel_frame_writer: RTL and testbench
=====================================

Name: pixel_frame_writer

Overview:
Downstream consumer of the camera controller's pixel stream (newPixel, pixelData, vsync, href). It synchronises the pclk-domain strobes into the system clock domain and tracks x/y position within each frame. Each pixel is buffered in a small FIFO and written to a frame-buffer memory port through a req/ack handshake. It sits between the OV7670 control block and the frame-buffer RAM/SRAM arbiter.

Parameters:
H_RES, 320, pixels per line stored
V_RES, 240, lines per frame stored
ADDR_WIDTH, 17, frame-buffer word-address width
BASE_ADDR, 0, address of pixel (0,0)
FIFO_DEPTH, 4, pixel FIFO entries (power of 2, >=2)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
vsync  in  1  camera vsync, pclk domain, high between frames
href  in  1  camera href, pclk domain, high during valid line
newPixel  in  1  pixel-complete level from the controller, pclk domain
pixelData  in  16  pixel value; stable for at least one pclk after newPixel rises
enable  in  1  arm capture; sampled only in IDLE
memAck  in  1  memory accepted current write
memWrReq  out  1  write request
memAddr  out  ADDR_WIDTH  write address
memData  out  16  write data
frameDone  out  1  one-cycle pulse when the last pixel of a frame is accepted by memory
overflow  out  1  sticky; pixel dropped because FIFO was full
busy  out  1  high in any state other than IDLE

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-high.
- Reset: state=IDLE; memWrReq=0, memAddr=0, memData=0, frameDone=0, overflow=0, busy=0; FIFO empty; x=y=0; all synchroniser flops 0.
- Synchronisers: vsync, href and newPixel each pass through 2 flops. A pixel event is the rising edge of synchronised newPixel (3rd flop compare). pixelData is registered on the pixel-event cycle. Latency from raw newPixel rise to FIFO push is 3 clk.
- States:
  - IDLE: if enable, go to WAIT_VS.
  - WAIT_VS: wait for synchronised vsync high, then go to WAIT_START. Clear overflow on entry.
  - WAIT_START: on synchronised vsync falling edge, set x=y=0 and go to CAPTURE.
  - CAPTURE: accept pixel events only while synchronised href=1.
  - DRAIN: go to IDLE once the FIFO is empty and the final memAck has been seen.
- Pixel handling in CAPTURE:
  - Push {addr, data}, where addr = BASE_ADDR + y*H_RES + x. Keep a running address counter; do not use a multiplier.
  - Then x++. If x reaches H_RES, further pixels on that line are discarded.
  - Synchronised href falling edge with x != 0: x=0, y++.
  - When y reaches V_RES, go to DRAIN.
  - Synchronised vsync rising while in CAPTURE (short frame): go to DRAIN.
- FIFO:
  - Push when full: pixel dropped, overflow=1 (sticky until next WAIT_VS entry), address counter still advances.
  - Simultaneous push and pop on a full FIFO is a legal pop-then-push; no drop.
- Memory handshake:
  - memWrReq=1 whenever the head entry is presented; memAddr and memData are held stable until memAck=1 is sampled.
  - On ack, pop. The next entry may be presented in the following cycle.
  - memAck while memWrReq=0 is ignored.
- frameDone: 1-cycle pulse on the ack of the last entry when leaving DRAIN.
- Reset mid-write: memWrReq drops the same cycle reset is sampled; the in-flight entry is discarded.
- Address arithmetic wraps modulo 2^ADDR_WIDTH.

Optional Feature:
Macro PIXEL_FRAME_WRITER_DECIMATE_EN.
- Defined: keep only pixels with even x and even line index (2x2 decimation). Stored frame is H_RES/2 x V_RES/2 with contiguous addresses BASE_ADDR + (y/2)*(H_RES/2) + x/2. The raw counters still span H_RES x V_RES for end-of-frame detection.
- Undefined: every in-window pixel is stored as above.

Test Plan:
- Reset, enable=1, one 320x240 frame with memAck tied 1 -> 76800 writes, addresses 0..76799 in order; frameDone pulses once; overflow=0; back to IDLE.
- 4-pixel line, 2 lines, H_RES=4, V_RES=2, memAck delayed 3 cycles each -> memAddr/memData stable while memWrReq is high; writes at 0,1,2,3,4,5,6,7; data matches pixelData.
- Hold memAck=0 for 6 pixel events with FIFO_DEPTH=4 -> 4 stored, 2 dropped, overflow=1; next frame's WAIT_VS clears overflow.
- 330 pixels on one line with H_RES=320 -> pixels 320..329 not written; next line starts at address 320.
- vsync rises after 100 lines -> DRAIN, FIFO empties, frameDone pulses, last address 100*320-1.
- Assert reset while memWrReq=1 -> next cycle memWrReq=0 and state IDLE; with DECIMATE_EN, a 4x4 frame writes 4 pixels at addresses 0..3.

Source files
------------

// File: rtl/pixel_frame_writer.sv
// Camera pixel stream to frame-buffer writer: synchronises pclk strobes, tracks x/y,
// buffers pixels in a FIFO and writes them via req/ack. Optional 2x2 decimation: PIXEL_FRAME_WRITER_DECIMATE_EN.
module pixel_frame_writer #(
    parameter int                    H_RES      = 320,
    parameter int                    V_RES      = 240,
    parameter int                    ADDR_WIDTH = 17,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    FIFO_DEPTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_vsync,
    input  logic                  i_href,
    input  logic                  i_newPixel,
    input  logic [15:0]           i_pixelData,
    input  logic                  i_enable,
    input  logic                  i_memAck,
    output logic                  o_memWrReq,
    output logic [ADDR_WIDTH-1:0] o_memAddr,
    output logic [15:0]           o_memData,
    output logic                  o_frameDone,
    output logic                  o_overflow,
    output logic                  o_busy
);
    localparam int XW = $clog2(H_RES + 1);
    localparam int YW = $clog2(V_RES + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int EW = ADDR_WIDTH + 16;
    localparam logic [XW-1:0] X_END    = XW'(H_RES);
    localparam logic [YW-1:0] Y_LAST   = YW'(V_RES - 1);
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(FIFO_DEPTH);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
`ifdef PIXEL_FRAME_WRITER_DECIMATE_EN
    localparam logic [ADDR_WIDTH-1:0] LINE_STEP = ADDR_WIDTH'(H_RES / 2);
`else
    localparam logic [ADDR_WIDTH-1:0] LINE_STEP = ADDR_WIDTH'(H_RES);
`endif

    typedef enum logic [2:0] {S_IDLE, S_WAIT_VS, S_WAIT_START, S_CAPTURE, S_DRAIN} state_t;
    state_t r_state, w_next;

    logic [2:0]            r_vs_sync, r_hr_sync, r_np_sync;
    logic [XW-1:0]         r_x;
    logic [YW-1:0]         r_y;
    logic [ADDR_WIDTH-1:0] r_addr, r_line_base;
    logic [EW-1:0]         r_fifo [FIFO_DEPTH];
    logic [PW-1:0]         r_wp, r_rp;
    logic [PW:0]           r_cnt;
    logic                  r_frameDone, r_overflow;

    logic w_vs, w_vs_rise, w_vs_fall, w_hr, w_hr_fall, w_pix;
    logic w_accept, w_keep, w_empty, w_full, w_pop, w_push, w_drop, w_line_end, w_start;

    // Bit 1 is the synchronised level, bit 2 its previous value for edge detection.
    assign w_vs      = r_vs_sync[1];
    assign w_vs_rise = r_vs_sync[1] & ~r_vs_sync[2];
    assign w_vs_fall = ~r_vs_sync[1] & r_vs_sync[2];
    assign w_hr      = r_hr_sync[1];
    assign w_hr_fall = ~r_hr_sync[1] & r_hr_sync[2];
    assign w_pix     = r_np_sync[1] & ~r_np_sync[2];

    assign w_accept   = (r_state == S_CAPTURE) && w_pix && w_hr && (r_x < X_END);
`ifdef PIXEL_FRAME_WRITER_DECIMATE_EN
    assign w_keep     = w_accept && !r_x[0] && !r_y[0];
`else
    assign w_keep     = w_accept;
`endif
    assign w_line_end = (r_state == S_CAPTURE) && w_hr_fall && (r_x != '0);
    assign w_start    = (r_state == S_WAIT_START) && w_vs_fall;
    assign w_empty    = (r_cnt == '0);
    assign w_full     = (r_cnt == CNT_FULL);
    assign w_pop      = i_memAck && !w_empty;
    assign w_push     = w_keep && (!w_full || w_pop);
    assign w_drop     = w_keep && w_full && !w_pop;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_vs_sync <= '0;
            r_hr_sync <= '0;
            r_np_sync <= '0;
        end else begin
            r_vs_sync <= {r_vs_sync[1:0], i_vsync};
            r_hr_sync <= {r_hr_sync[1:0], i_href};
            r_np_sync <= {r_np_sync[1:0], i_newPixel};
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:       if (i_enable) w_next = S_WAIT_VS;
            S_WAIT_VS:    if (w_vs) w_next = S_WAIT_START;
            S_WAIT_START: if (w_vs_fall) w_next = S_CAPTURE;
            S_CAPTURE:    if (w_vs_rise || (w_line_end && r_y == Y_LAST)) w_next = S_DRAIN;
            S_DRAIN:      if (w_empty || (w_pop && r_cnt == CNT_ONE)) w_next = S_IDLE;
            default:      w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_frameDone <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_frameDone <= (r_state == S_DRAIN) && (w_next == S_IDLE);
            if (r_state == S_IDLE && w_next == S_WAIT_VS)
                r_overflow <= 1'b0;
            else if (w_drop)
                r_overflow <= 1'b1;
        end
    end

    // Running address: line_base tracks the first stored address of the current line.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_x         <= '0;
            r_y         <= '0;
            r_addr      <= '0;
            r_line_base <= '0;
        end else if (w_start) begin
            r_x         <= '0;
            r_y         <= '0;
            r_addr      <= BASE_ADDR;
            r_line_base <= BASE_ADDR;
        end else if (w_line_end) begin
            r_x <= '0;
            r_y <= r_y + 1'b1;
`ifdef PIXEL_FRAME_WRITER_DECIMATE_EN
            if (!r_y[0]) begin
                r_line_base <= r_line_base + LINE_STEP;
                r_addr      <= r_line_base + LINE_STEP;
            end else begin
                r_addr      <= r_line_base;
            end
`else
            r_line_base <= r_line_base + LINE_STEP;
            r_addr      <= r_line_base + LINE_STEP;
`endif
        end else begin
            if (w_accept) r_x <= r_x + 1'b1;
            if (w_keep)   r_addr <= r_addr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) r_fifo[i] <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_wp] <= {r_addr, i_pixelData};
                r_wp         <= r_wp + 1'b1;
            end
            if (w_pop) r_rp <= r_rp + 1'b1;
            if (w_push && !w_pop)
                r_cnt <= r_cnt + 1'b1;
            else if (!w_push && w_pop)
                r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_memWrReq             = !w_empty && !i_reset;
    assign {o_memAddr, o_memData} = r_fifo[r_rp];
    assign o_frameDone            = r_frameDone;
    assign o_overflow             = r_overflow;
    assign o_busy                 = (r_state != S_IDLE);

endmodule

// File: tb/tb_pixel_frame_writer.sv
// Randomised bench for pixel_frame_writer: drives camera frames and a memory ack model,
// checks every write against an address/data list computed from frame geometry.
module tb_pixel_frame_writer;
    localparam int          H    = 10;
    localparam int          V    = 6;
    localparam int          D    = 4;
    localparam logic [16:0] BASE = 17'h1FFF0;
`ifdef PIXEL_FRAME_WRITER_DECIMATE_EN
    localparam bit DEC = 1'b1;
`else
    localparam bit DEC = 1'b0;
`endif

    logic        clk, reset, vsync, href, newPixel, enable, memAck;
    logic [15:0] pixelData;
    logic        memWrReq, frameDone, overflow, busy;
    logic [16:0] memAddr;
    logic [15:0] memData;

    int checks = 0, failures = 0;
    int ack_mode = 0;
    int fd_cnt = 0, mon_viol = 0;
    int fd_base, viol_base, got_base, my_y;
    bit exp_ovf;
    logic [16:0] exp_a[$], got_a[$];
    logic [15:0] exp_d[$], got_d[$];

    pixel_frame_writer #(.H_RES(H), .V_RES(V), .ADDR_WIDTH(17), .BASE_ADDR(BASE), .FIFO_DEPTH(D)) dut (
        .i_clk(clk), .i_reset(reset), .i_vsync(vsync), .i_href(href), .i_newPixel(newPixel),
        .i_pixelData(pixelData), .i_enable(enable), .i_memAck(memAck),
        .o_memWrReq(memWrReq), .o_memAddr(memAddr), .o_memData(memData),
        .o_frameDone(frameDone), .o_overflow(overflow), .o_busy(busy));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: 0 = ack always high, 1 = random 0..3 cycle delay per write, 2 = ack held low.
    initial begin
        int dly;
        dly = 0;
        memAck = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (ack_mode)
                0: memAck = 1'b1;
                1: if (memAck) begin
                       memAck = 1'b0;
                       dly = $urandom_range(0, 3);
                   end else if (memWrReq) begin
                       if (dly == 0) memAck = 1'b1; else dly--;
                   end
                default: memAck = 1'b0;
            endcase
        end
    end

    // Write monitor: records accepted writes, frameDone cycles and hold-stability violations.
    initial begin
        logic pr, pa;
        logic [16:0] paddr;
        logic [15:0] pdata;
        pr = 0; pa = 0; paddr = '0; pdata = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (pr && !pa && memWrReq && (memAddr !== paddr || memData !== pdata)) mon_viol++;
                if (memWrReq && memAck) begin
                    got_a.push_back(memAddr);
                    got_d.push_back(memData);
                end
                if (frameDone) fd_cnt++;
            end
            pr = memWrReq && !reset; pa = memAck; paddr = memAddr; pdata = memData;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_pixel(input logic [15:0] d);
        pixelData = d; newPixel = 1'b1; tick(3);
        newPixel = 1'b0; tick(3);
    endtask

    task automatic wait_drain;
        int n;
        n = 0;
        while (memWrReq === 1'b1 && n < 300) begin tick(1); n++; end
        checks++;
        if (memWrReq !== 1'b0) begin
            failures++;
            $display("FAIL drain_timeout memWrReq=%b expected 0", memWrReq);
        end
    endtask

    // One href line of n pixels; held=1 keeps memAck low for the whole line.
    task automatic send_line(input int n, input bit held);
        int kept, save;
        logic [15:0] d;
        logic [16:0] a;
        kept = 0;
        save = ack_mode;
        if (held) ack_mode = 2;
        href = 1'b1; tick(2);
        for (int i = 0; i < n; i++) begin
            d = 16'($urandom);
            if (i < H && (!DEC || (i % 2 == 0 && my_y % 2 == 0))) begin
                if (DEC) a = BASE + 17'((my_y / 2) * (H / 2) + i / 2);
                else     a = BASE + 17'(my_y * H + i);
                if (!held || kept < D) begin
                    exp_a.push_back(a);
                    exp_d.push_back(d);
                end else begin
                    exp_ovf = 1'b1;
                end
                kept++;
            end
            send_pixel(d);
        end
        href = 1'b0; tick(3);
        if (n > 0) my_y++;
        ack_mode = save;
        wait_drain();
    endtask

    task automatic start_frame;
        exp_a.delete(); exp_d.delete();
        got_base = got_a.size(); fd_base = fd_cnt; viol_base = mon_viol;
        exp_ovf = 1'b0; my_y = 0;
        enable = 1'b1; tick(2); enable = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin failures++; $display("FAIL overflow_clear got=%b expected 0", overflow); end
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL armed_busy got=%b expected 1", busy); end
        vsync = 1'b1; tick(4); vsync = 1'b0; tick(4);
    endtask

    task automatic end_frame(input string name);
        int n;
        n = 0;
        vsync = 1'b1; tick(4); vsync = 1'b0;
        while (busy !== 1'b0 && n < 500) begin tick(1); n++; end
        tick(2);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL %s idle_timeout busy=%b expected 0", name, busy); end
        checks++;
        if (got_a.size() - got_base != exp_a.size()) begin
            failures++;
            $display("FAIL %s write_count got=%0d expected %0d", name, got_a.size() - got_base, exp_a.size());
        end
        for (int i = 0; i < exp_a.size() && got_base + i < got_a.size(); i++) begin
            checks++;
            if (got_a[got_base+i] !== exp_a[i] || got_d[got_base+i] !== exp_d[i]) begin
                failures++;
                $display("FAIL %s write[%0d] got addr=%h data=%h expected addr=%h data=%h",
                         name, i, got_a[got_base+i], got_d[got_base+i], exp_a[i], exp_d[i]);
            end
        end
        checks++;
        if (fd_cnt - fd_base != 1) begin failures++; $display("FAIL %s frame_done cycles=%0d expected 1", name, fd_cnt - fd_base); end
        checks++;
        if (overflow !== exp_ovf) begin failures++; $display("FAIL %s overflow got=%b expected %b", name, overflow, exp_ovf); end
        checks++;
        if (mon_viol - viol_base != 0) begin failures++; $display("FAIL %s hold_stable violations=%0d expected 0", name, mon_viol - viol_base); end
    endtask

    task automatic test_reset;
        reset = 1'b1; tick(3); reset = 1'b0; tick(1);
        checks++; if (memWrReq !== 1'b0)  begin failures++; $display("FAIL reset_req got=%b expected 0", memWrReq); end
        checks++; if (memAddr !== 17'd0)  begin failures++; $display("FAIL reset_addr got=%h expected 0", memAddr); end
        checks++; if (memData !== 16'd0)  begin failures++; $display("FAIL reset_data got=%h expected 0", memData); end
        checks++; if (frameDone !== 1'b0) begin failures++; $display("FAIL reset_done got=%b expected 0", frameDone); end
        checks++; if (overflow !== 1'b0)  begin failures++; $display("FAIL reset_ovf got=%b expected 0", overflow); end
        checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL reset_busy got=%b expected 0", busy); end
    endtask

    task automatic test_full_frame;
        ack_mode = 0;
        start_frame();
        while (my_y < V) send_line(H, 1'b0);
        end_frame("full_frame");
    endtask

    task automatic test_delayed_ack;
        ack_mode = 1;
        start_frame();
        for (int k = 0; k < 40 && my_y < V; k++)
            send_line(($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, H + 3)), 1'b0);
        end_frame("delayed_ack");
    endtask

    task automatic test_long_line;
        ack_mode = 1;
        start_frame();
        send_line(H + 3, 1'b0);
        send_line(H, 1'b0);
        send_line(2, 1'b0);
        end_frame("long_line");
    endtask

    task automatic test_short_frame;
        ack_mode = 0;
        start_frame();
        for (int k = 0; k < 3; k++) send_line($urandom_range(1, H), 1'b0);
        end_frame("short_frame");
    endtask

    task automatic test_overflow;
        ack_mode = 1;
        start_frame();
        send_line(H, 1'b1);
        send_line(H, 1'b0);
        send_line(H, 1'b0);
        end_frame("overflow");
        start_frame();
        send_line(4, 1'b0);
        end_frame("after_overflow");
    endtask

    task automatic test_reset_mid_write;
        ack_mode = 2;
        start_frame();
        href = 1'b1; tick(2);
        send_pixel(16'hA5A5);
        send_pixel(16'h5A5A);
        checks++;
        if (memWrReq !== 1'b1) begin failures++; $display("FAIL midwrite_req got=%b expected 1", memWrReq); end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++; if (memWrReq !== 1'b0) begin failures++; $display("FAIL reset_drop_req got=%b expected 0", memWrReq); end
        checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL reset_drop_busy got=%b expected 0", busy); end
        @(negedge clk);
        reset = 1'b0; href = 1'b0; ack_mode = 0;
        tick(5);
        checks++; if (memWrReq !== 1'b0) begin failures++; $display("FAIL discard_req got=%b expected 0", memWrReq); end
        checks++;
        if (got_a.size() != got_base) begin failures++; $display("FAIL discard_writes got=%0d expected 0", got_a.size() - got_base); end
        start_frame();
        send_line(3, 1'b0);
        end_frame("after_reset");
    endtask

    initial begin
        reset = 1'b1; vsync = 1'b0; href = 1'b0; newPixel = 1'b0; enable = 1'b0; pixelData = '0;
        test_reset();
        test_full_frame();
        test_delayed_ack();
        test_long_line();
        test_short_frame();
        test_overflow();
        test_delayed_ack();
        test_reset_mid_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
